qpu_exu_trigger: RTL and testbench

Timing-side consumer of the QPU event/time queue. It owns the absolute QPU time counter that the queue compares its head timestamp against, and it honours the queue's clock-enable back-pressure. It turns the queue's per-channel event outputs into registered AWG codeword strobes and measurement requests. Measurement results come back into per-qubit zero/one/equ feedback flags, which drive the queue's conditional (fast-feedback) event gating. The block sits between the execution-unit queue and the analog front end (AWG channels, readout unit).

---
 rtl/qpu_exu_trigger.sv | 207 ++++++++++++++++++++
 tb/tb_qpu_exu_trigger.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/qpu_exu_trigger.sv
// QPU time base, AWG codeword strobes and measurement feedback for the event queue.
// Optional measurement watchdog enabled by defining QPU_TRIGGER_MEAS_TIMEOUT_EN.
module qpu_exu_trigger #(
   parameter int unsigned TIME_WIDTH   = 16,
   parameter int unsigned QI_NUM       = 4,
   parameter int unsigned QI_W         = 8,
   parameter int unsigned MEAS_NUM     = 1,
   parameter int unsigned QUBIT_NUM    = 4,
   parameter int unsigned MEAS_TIMEOUT = 1023
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   i_start,
   input  logic                                   i_stop,
   output logic                                   o_trigger,
   input  logic                                   i_clk_ena,
   output logic [TIME_WIDTH-1:0]                  o_clk,
   input  logic [QI_NUM+MEAS_NUM-1:0]             i_evq_valid,
   input  logic [QI_NUM*QI_W+MEAS_NUM*QUBIT_NUM-1:0] i_evq_data,
   output logic [QI_NUM-1:0]                      awg_o_valid,
   output logic [QI_NUM*QI_W-1:0]                 awg_o_code,
   output logic                                   meas_o_req,
   output logic [QUBIT_NUM-1:0]                   meas_o_mask,
   input  logic                                   meas_i_rsp_valid,
   input  logic [QUBIT_NUM-1:0]                   meas_i_result,
   output logic [QUBIT_NUM-1:0]                   qubit_measure_zero,
   output logic [QUBIT_NUM-1:0]                   qubit_measure_one,
   output logic [QUBIT_NUM-1:0]                   qubit_measure_equ,
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
   output logic                                   o_meas_timeout,
`endif
   output logic                                   o_meas_busy
);

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   state_e                state_q, state_d;
   logic [TIME_WIDTH-1:0] time_q, time_d;

   always_comb begin
      state_d = state_q;
      time_d  = time_q;
      unique case (state_q)
         StIdle: if (i_start && !i_stop) begin
            state_d = StRun;
            time_d  = '0;
         end
         StRun: begin
            if (i_clk_ena) time_d = time_q + 1'b1;
            if (i_stop)          state_d = StIdle;
            else if (!i_clk_ena) state_d = StHold;
         end
         StHold: begin
            if (i_stop)         state_d = StIdle;
            else if (i_clk_ena) state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         time_q  <= '0;
      end else begin
         state_q <= state_d;
         time_q  <= time_d;
      end
   end

   assign o_trigger = (state_q != StIdle);
   assign o_clk     = time_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         awg_o_valid <= '0;
         awg_o_code  <= '0;
      end else begin
         awg_o_valid <= i_evq_valid[QI_NUM-1:0];
         for (int l = 0; l < QI_NUM; l++) begin
            if (i_evq_valid[l]) awg_o_code[l*QI_W +: QI_W] <= i_evq_data[l*QI_W +: QI_W];
         end
      end
   end

   logic [QUBIT_NUM-1:0] req_mask, launch;
   logic [QUBIT_NUM-1:0] issued_q, issued_d, pending_q, pending_d, mask_q, mask_d;
   logic [QUBIT_NUM-1:0] one_q, one_d, zero_q, zero_d, equ_q, equ_d, prev_q, prev_d;
   logic                 busy_q, busy_d, req_q, req_d, rsp;
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MEAS_TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tmo_q, tmo_d;
`endif

   always_comb begin
      req_mask = '0;
      for (int m = 0; m < MEAS_NUM; m++) begin
         if (i_evq_valid[QI_NUM+m]) begin
            req_mask = req_mask | i_evq_data[QI_NUM*QI_W + m*QUBIT_NUM +: QUBIT_NUM];
         end
      end
   end

   always_comb begin
      busy_d    = busy_q;
      issued_d  = issued_q;
      pending_d = pending_q;
      req_d     = 1'b0;
      mask_d    = mask_q;
      one_d     = one_q;
      zero_d    = zero_q;
      equ_d     = equ_q;
      prev_d    = prev_q;
      rsp       = meas_i_rsp_valid && busy_q;
      launch    = pending_q | req_mask;
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
      tmo_d = tmo_q;
      cnt_d = (busy_q && !rsp) ? cnt_q + 1'b1 : '0;
`endif
      if (rsp) begin
         for (int q = 0; q < QUBIT_NUM; q++) begin
            if (issued_q[q]) begin
               one_d[q]  = meas_i_result[q];
               zero_d[q] = ~meas_i_result[q];
               equ_d[q]  = (meas_i_result[q] == prev_q[q]);
               prev_d[q] = meas_i_result[q];
            end
         end
         pending_d = '0;
         if (launch != '0) begin
            req_d    = 1'b1;
            mask_d   = launch;
            issued_d = launch;
         end else begin
            busy_d   = 1'b0;
            issued_d = '0;
         end
      end else if (busy_q) begin
         pending_d = pending_q | req_mask;
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
         if (cnt_q == CNT_W'(MEAS_TIMEOUT - 1)) begin
            busy_d    = 1'b0;
            issued_d  = '0;
            pending_d = '0;
            tmo_d     = 1'b1;
            cnt_d     = '0;
         end
`endif
      end else if (req_mask != '0) begin
         req_d    = 1'b1;
         mask_d   = req_mask;
         issued_d = req_mask;
         busy_d   = 1'b1;
      end
      // Outstanding qubits read 0 so conditional events evaluate false until the result lands.
      one_d  = one_d & ~(issued_d | pending_d);
      zero_d = zero_d & ~(issued_d | pending_d);
      equ_d  = equ_d & ~(issued_d | pending_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= 1'b0;
         issued_q  <= '0;
         pending_q <= '0;
         req_q     <= 1'b0;
         mask_q    <= '0;
         one_q     <= '0;
         zero_q    <= '0;
         equ_q     <= '0;
         prev_q    <= '0;
      end else begin
         busy_q    <= busy_d;
         issued_q  <= issued_d;
         pending_q <= pending_d;
         req_q     <= req_d;
         mask_q    <= mask_d;
         one_q     <= one_d;
         zero_q    <= zero_d;
         equ_q     <= equ_d;
         prev_q    <= prev_d;
      end
   end

`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tmo_q <= tmo_d;
      end
   end

   assign o_meas_timeout = tmo_q;
`endif

   assign meas_o_req         = req_q;
   assign meas_o_mask        = mask_q;
   assign o_meas_busy        = busy_q;
   assign qubit_measure_one  = one_q;
   assign qubit_measure_zero = zero_q;
   assign qubit_measure_equ  = equ_q;

endmodule

// File: tb/tb_qpu_exu_trigger.sv
// Directed bench for qpu_exu_trigger: time base, hold/wrap, AWG strobes, measurement feedback.
module tb_qpu_exu_trigger;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_start, i_stop, i_clk_ena;
   logic        o_trigger;
   logic [15:0] o_clk;
   logic [4:0]  i_evq_valid;
   logic [35:0] i_evq_data;
   logic [3:0]  awg_o_valid;
   logic [31:0] awg_o_code;
   logic        meas_o_req;
   logic [3:0]  meas_o_mask;
   logic        meas_i_rsp_valid;
   logic [3:0]  meas_i_result;
   logic [3:0]  q_zero, q_one, q_equ;
   logic        o_meas_busy;
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
   logic        o_meas_timeout;
`endif

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   qpu_exu_trigger #(
      .TIME_WIDTH  (16),
      .QI_NUM      (4),
      .QI_W        (8),
      .MEAS_NUM    (1),
      .QUBIT_NUM   (4),
      .MEAS_TIMEOUT(8)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .i_start           (i_start),
      .i_stop            (i_stop),
      .o_trigger         (o_trigger),
      .i_clk_ena         (i_clk_ena),
      .o_clk             (o_clk),
      .i_evq_valid       (i_evq_valid),
      .i_evq_data        (i_evq_data),
      .awg_o_valid       (awg_o_valid),
      .awg_o_code        (awg_o_code),
      .meas_o_req        (meas_o_req),
      .meas_o_mask       (meas_o_mask),
      .meas_i_rsp_valid  (meas_i_rsp_valid),
      .meas_i_result     (meas_i_result),
      .qubit_measure_zero(q_zero),
      .qubit_measure_one (q_one),
      .qubit_measure_equ (q_equ),
`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
      .o_meas_timeout    (o_meas_timeout),
`endif
      .o_meas_busy       (o_meas_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic meas_event(input logic [3:0] mask);
      i_evq_valid = 5'b10000;
      i_evq_data  = '0;
      i_evq_data[35:32] = mask;
      tick();
      i_evq_valid = '0;
   endtask

   task automatic respond(input logic [3:0] res);
      meas_i_rsp_valid = 1'b1;
      meas_i_result    = res;
      tick();
      meas_i_rsp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; i_start = 0; i_stop = 0; i_clk_ena = 0;
      i_evq_valid = '0; i_evq_data = '0; meas_i_rsp_valid = 0; meas_i_result = '0;
      tick(); tick();
      rst = 1'b0;
      check("rst_trigger", o_trigger, 0);
      check("rst_clk", o_clk, 0);
      check("rst_awg_valid", awg_o_valid, 0);
      check("rst_awg_code", awg_o_code, 0);
      check("rst_req", meas_o_req, 0);
      check("rst_mask", meas_o_mask, 0);
      check("rst_flags", {q_zero, q_one, q_equ}, 0);
      check("rst_busy", o_meas_busy, 0);

      i_start = 1; i_clk_ena = 1;
      tick();
      i_start = 0;
      check("start_trigger", o_trigger, 1);
      check("start_clk", o_clk, 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("count", o_clk, k);
      end

      i_clk_ena = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("hold_clk", o_clk, 4);
      end
      check("hold_trigger", o_trigger, 1);
      i_clk_ena = 1;
      tick();
      check("resume_first", o_clk, 4);
      tick();
      check("resume_inc", o_clk, 5);

      for (int k = 0; k < 65530; k++) tick();
      check("pre_wrap", o_clk, 16'hFFFF);
      tick();
      check("wrap", o_clk, 16'h0000);

      i_evq_valid = 5'b00100;
      i_evq_data  = '0;
      i_evq_data[23:16] = 8'hA5;
      tick();
      i_evq_valid = '0;
      i_evq_data  = '0;
      check("awg_strobe", awg_o_valid, 4'b0100);
      check("awg_code", awg_o_code, 32'h00A5_0000);
      tick();
      check("awg_strobe_end", awg_o_valid, 4'b0000);
      check("awg_code_held", awg_o_code, 32'h00A5_0000);

      meas_event(4'b0011);
      check("meas_req", meas_o_req, 1);
      check("meas_mask", meas_o_mask, 4'b0011);
      check("meas_busy", o_meas_busy, 1);
      meas_event(4'b0100);
      check("meas_no_req_busy", meas_o_req, 0);
      respond(4'b0001);
      check("rsp1_one", q_one, 4'b0001);
      check("rsp1_zero", q_zero, 4'b0010);
      check("rsp1_equ", q_equ, 4'b0010);
      check("pend_req", meas_o_req, 1);
      check("pend_mask", meas_o_mask, 4'b0100);
      check("pend_busy", o_meas_busy, 1);
      tick();
      check("pend_req_end", meas_o_req, 0);
      respond(4'b0100);
      check("rsp2_one", q_one, 4'b0101);
      check("rsp2_zero", q_zero, 4'b0010);
      check("rsp2_equ", q_equ, 4'b0010);
      check("rsp2_busy", o_meas_busy, 0);
      check("rsp2_no_req", meas_o_req, 0);

      i_stop = 1;
      tick();
      i_stop = 0;
      check("stop_trigger", o_trigger, 0);
      i_start = 1; i_stop = 1;
      tick();
      i_start = 0; i_stop = 0;
      check("start_stop_idle", o_trigger, 0);

      i_start = 1;
      tick();
      i_start = 0;
      check("restart_trigger", o_trigger, 1);
      check("restart_clk", o_clk, 0);
      meas_event(4'b1000);
      check("m3_busy", o_meas_busy, 1);
      check("m3_mask", meas_o_mask, 4'b1000);
      i_stop = 1;
      tick();
      i_stop = 0;
      check("stop_busy_trigger", o_trigger, 0);
      check("stop_busy_still", o_meas_busy, 1);
      respond(4'b1000);
      check("rsp3_one", q_one, 4'b1101);
      check("rsp3_zero", q_zero, 4'b0010);
      check("rsp3_equ", q_equ, 4'b0010);
      check("rsp3_busy", o_meas_busy, 0);

      respond(4'b1111);
      check("idle_rsp_one", q_one, 4'b1101);
      check("idle_rsp_equ", q_equ, 4'b0010);

      meas_event(4'b0001);
      check("m4_flag_cleared", q_one, 4'b1100);
      rst = 1;
      tick();
      rst = 0;
      check("midrst_busy", o_meas_busy, 0);
      check("midrst_flags", {q_zero, q_one, q_equ}, 0);
      tick();
      check("midrst_no_req", meas_o_req, 0);

`ifdef QPU_TRIGGER_MEAS_TIMEOUT_EN
      meas_event(4'b0010);
      for (int k = 0; k < 7; k++) tick();
      check("tmo_not_yet", o_meas_timeout, 0);
      tick();
      check("tmo_set", o_meas_timeout, 1);
      check("tmo_busy", o_meas_busy, 0);
      tick();
      check("tmo_sticky", o_meas_timeout, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
